// File: rtl/ula_pkg.sv
// Shared definitions for the ULA datapath units.
package ula_pkg;

  // Datapath width of every ULA unit.
  localparam int unsigned LARGURA = 4;

  // Sequential divider control states.
  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    FIM
  } estado_div_t;

endpackage

// File: rtl/somador.sv
// 4-bit ripple-carry adder; the divider uses it as a trial subtractor (a + ~b + 1).
module somador
  import ula_pkg::*;
(
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               cin,
  output logic [LARGURA-1:0] soma,
  output logic               cout
);

  logic [LARGURA:0] carry;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    carry    = '0;
    soma     = '0;
    carry[0] = cin;
    for (int i = 0; i < LARGURA; i++) begin
      soma[i]    = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[LARGURA];
  end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per clock.
module divisor_sequencial
  import ula_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  estado_div_t        estado_q, estado_d;
  logic [LARGURA-1:0] q_q, q_d;
  logic [LARGURA-1:0] r_q, r_d;
  logic [LARGURA-1:0] d_q, d_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [LARGURA-1:0] quoc_q, quoc_d;
  logic [LARGURA-1:0] resto_q, resto_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // Partial remainder shifted left with the next dividend bit; 5 bits since R < D.
  logic [LARGURA:0]   s;
  logic [LARGURA-1:0] dif;
  logic               cout;
  logic               ge;

  assign s  = {r_q, q_q[LARGURA-1]};
  assign ge = s[LARGURA] | cout;

  somador u_somador (
    .a    (s[LARGURA-1:0]),
    .b    (~d_q),
    .cin  (1'b1),
    .soma (dif),
    .cout (cout)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    estado_d = estado_q;
    q_d      = q_q;
    r_d      = r_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    quoc_d   = quoc_q;
    resto_d  = resto_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (estado_q)
      OCIOSO: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor != '0) begin
            q_d      = dividendo;
            d_d      = divisor;
            r_d      = '0;
            cnt_d    = '0;
            dz_d     = 1'b0;
            estado_d = CALCULA;
          end else begin
            // Divide-by-zero skips the iterations and reports immediately.
            dz_d     = 1'b1;
            quoc_d   = '1;
            resto_d  = dividendo;
            done_d   = 1'b1;
            estado_d = FIM;
          end
        end
      end
      CALCULA: begin
        r_d   = ge ? dif : s[LARGURA-1:0];
        q_d   = {q_q[LARGURA-2:0], ge};
        cnt_d = cnt_q + 2'd1;
        // Counter wrapping 3 -> 0 marks the last step; results load on FIM entry.
        if (cnt_q == 2'd3) begin
          quoc_d   = q_d;
          resto_d  = r_d;
          done_d   = 1'b1;
          estado_d = FIM;
        end
      end
      FIM: begin
        busy_d   = 1'b0;
        estado_d = OCIOSO;
      end
      default: begin
        busy_d   = 1'b0;
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      q_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      quoc_q   <= '0;
      resto_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      q_q      <= q_d;
      r_q      <= r_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      quoc_q   <= quoc_d;
      resto_q  <= resto_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign quociente = quoc_q;
  assign resto     = resto_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: cycle-level reference model plus literal checks.
module tb_divisor_sequencial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividendo;
  logic [3:0] divisor;
  logic [3:0] quociente;
  logic [3:0] resto;
  logic       busy;
  logic       done;
  logic       div_zero;

  int n_tests;
  int n_fail;

  divisor_sequencial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted request is busy for cycles 1..lat after the
  // accepting edge, done in cycle lat (5 normal, 1 divide-by-zero), results from / and %.
  logic       m_act;
  int         m_c;
  int         m_lat;
  logic [3:0] m_a, m_b, m_q, m_r;
  logic       m_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_c   <= 0;
      m_lat <= 0;
      m_a   <= '0;
      m_b   <= '0;
      m_q   <= '0;
      m_r   <= '0;
      m_dz  <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_c   <= 1;
        m_a   <= dividendo;
        m_b   <= divisor;
        if (divisor == 4'd0) begin
          m_lat <= 1;
          m_dz  <= 1'b1;
          m_q   <= 4'hF;
          m_r   <= dividendo;
        end else begin
          m_lat <= 5;
          m_dz  <= 1'b0;
        end
      end
    end else if (m_c == m_lat) begin
      m_act <= 1'b0;
    end else begin
      m_c <= m_c + 1;
      if (m_c + 1 == m_lat) begin
        m_q <= m_a / m_b;
        m_r <= m_a % m_b;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Advance one cycle; compare every output with the model on the falling edge.
  task automatic tick();
    logic e_done;
    @(negedge clk);
    e_done = m_act && (m_c == m_lat);
    n_tests++;
    if (busy !== m_act || done !== e_done || div_zero !== m_dz ||
        quociente !== m_q || resto !== m_r) begin
      n_fail++;
      $display("FAIL model t=%0t: got busy=%b done=%b dz=%b q=%0d r=%0d, expected busy=%b done=%b dz=%b q=%0d r=%0d",
               $time, busy, done, div_zero, quociente, resto, m_act, e_done, m_dz, m_q, m_r);
    end
    #1;
  endtask

  // Present a request for one accepting edge; afterwards scramble inputs to prove capture.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    start     = 1'b1;
    dividendo = a;
    divisor   = b;
    tick();
    start     = 1'b0;
    dividendo = 4'($urandom);
    divisor   = 4'($urandom);
  endtask

  // Wait (bounded) for done, then check latency, results and hold behaviour.
  task automatic wait_done(input int n0, input int eq, input int er, input int edz,
                           input int elat);
    int n;
    n = n0;
    while (!done && n < 12) begin
      tick();
      n++;
    end
    check("done_seen", int'(done), 1);
    check("latency", n, elat);
    check("quociente", int'(quociente), eq);
    check("resto", int'(resto), er);
    check("div_zero", int'(div_zero), edz);
    tick();
    check("done_pulse", int'(done), 0);
    check("hold_q", int'(quociente), eq);
    check("hold_r", int'(resto), er);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividendo = '0;
    divisor   = '0;
    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quociente), 0);
    rst_n = 1'b1;
    tick();

    // Hand-computed cases.
    start_op(4'd13, 4'd4);  wait_done(1, 3, 1, 0, 5);
    start_op(4'd15, 4'd1);  wait_done(1, 15, 0, 0, 5);
    start_op(4'd14, 4'd15); wait_done(1, 0, 14, 0, 5);
    start_op(4'd15, 4'd8);  wait_done(1, 1, 7, 0, 5);
    start_op(4'd3, 4'd7);   wait_done(1, 0, 3, 0, 5);
    start_op(4'd9, 4'd0);   wait_done(1, 15, 9, 1, 1);

    // Start pulse during the 2nd CALCULA cycle must be ignored.
    start_op(4'd12, 4'd5);
    tick();
    start     = 1'b1;
    dividendo = 4'd15;
    divisor   = 4'd3;
    tick();
    start = 1'b0;
    wait_done(3, 2, 2, 0, 5);

    // Reset in the 3rd CALCULA cycle clears outputs immediately.
    start_op(4'd13, 4'd4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_dz", int'(div_zero), 0);
    check("midrst_q", int'(quociente), 0);
    check("midrst_r", int'(resto), 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_op(4'd7, 4'd2); wait_done(1, 3, 1, 0, 5);

    // Exhaustive sweep of nonzero divisors, back to back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_done(1, a / b, a % b, 0, 5);
      end
    end

    // Random traffic with occasional resets; the per-cycle model compare covers it.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 2) == 0);
      dividendo = 4'($urandom);
      divisor   = 4'($urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
